dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Single-cycle arbiter/sequencer sharing the single-port data memory (DM, 4096 words, byte-enabled, combinational read, write on posedge clk) between two requesters: m0 (CPU load/store port) and m1 (loader/debug port).
- Per access it:
  - picks a winner by round-robin;
  - generates byte enables and write-lane data from size and address;
  - checks alignment and range;
  - returns extracted, extended read data one cycle later.
- Sits between the requesters and DM; DM's A/MemWrite/WD/BE/RD connect directly to the dm_* ports.

Parameters:
- ADDR_MAX, 32'h0000_2fff, highest legal byte address.
- LOCK_MAX, 8, maximum consecutive locked grants before forced release.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- m0_req  in  1  access request.
- m0_we  in  1  1=store, 0=load.
- m0_addr  in  32  byte address.
- m0_wdata  in  32  store data, right-aligned.
- m0_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- m0_sext  in  1  sign-extend load result.
- m0_lock  in  1  request to keep the grant next cycle.
- m0_gnt  out  1  request accepted this cycle (combinational).
- m0_rvalid  out  1  registered; response valid this cycle.
- m0_rdata  out  32  registered load result.
- m0_err  out  1  registered; accepted access was misaligned, illegal or out of range.
- m1_req, m1_we, m1_addr, m1_wdata, m1_size, m1_sext, m1_lock, m1_gnt, m1_rvalid, m1_rdata, m1_err  same as m0_*.
- dm_A  out  32  address to DM.
- dm_MemWrite  out  1  DM write enable.
- dm_WD  out  32  lane-replicated write data.
- dm_BE  out  4  byte enables.
- dm_RD  in  32  DM read word.

Behaviour:
- Reset: all gnt/rvalid/err=0, rdata=0, rr pointer favours m0, lock owner=none, lock counter=0.
- Idle: dm_A=0, dm_MemWrite=0, dm_WD=0, dm_BE=0 whenever no grant.
- Arbitration (cycle T, combinational): at most one gnt.
  - Lock owner active (owner req && lock && lock_cnt<LOCK_MAX): owner wins.
  - Else if only one requests: it wins.
  - Else if both request: the one not granted last wins.
  - Registered state updated at posedge: last-winner, lock owner, lock_cnt.
- Lock:
  - lock_cnt increments each consecutive grant to the same lock owner.
  - At LOCK_MAX the other requester (if requesting) wins the next arbitration; lock_cnt clears whenever ownership changes or the owner drops req/lock.
- Lanes, from addr[1:0]:
  - byte: BE=0001<<addr[1:0], WD={4{wdata[7:0]}}.
  - half: BE=addr[1]?1100:0011, WD={2{wdata[15:0]}}.
  - word: BE=1111, WD=wdata.
  - dm_A=addr.
- Error cases:
  - Illegal: half with addr[0]=1, word with addr[1:0]!=0, size=11, or addr>ADDR_MAX.
  - Still granted, dm_MemWrite=0, dm_BE=0; response at T+1 has rdata=0, err=1.
- Write: dm_MemWrite=we for legal accesses; the DM commits at posedge ending T.
- Load response (T+1): rvalid=1, err=0.
  - rdata = selected byte/half of dm_RD sampled at end of T, sign- or zero-extended per sext; word unchanged.
  - Stores also return rvalid=1, rdata=0.
- rvalid/err for a master are high exactly one cycle per accepted access; a master may issue back-to-back (throughput 1/cycle).
- Read-after-write: a load in T+1 to the address stored in T returns the new data (DM already updated).
- Reset mid-operation: a pending response is dropped (rvalid=0 next cycle). A write granted in the reset cycle is suppressed: all outputs forced idle while reset=1.

Test Plan:
- Reset, then m0 word store addr 0x10 wdata 0xDEADBEEF; next cycle m0 byte load addr 0x11 sext=1 -> dm_BE=1111 on store; rdata=0xFFFFFFBE, rvalid=1, err=0.
- m1 half store addr 0x22 wdata 0x1234 -> dm_BE=1100, dm_WD=0x12341234; half load addr 0x22 sext=0 -> rdata=0x00001234.
- Both req every cycle, no lock -> grants alternate m0,m1,m0,m1 from reset; each rvalid one cycle after its gnt.
- m1 holds lock+req, m0 requests continuously -> m1 granted 8 consecutive cycles, then m0 granted; lock_cnt restarts.
- Word store addr 0x2 or addr 0x3000 -> gnt=1, dm_MemWrite=0, err=1 next cycle, rdata=0; memory unchanged on readback.
- Assert reset while m0 load granted -> no rvalid next cycle; all outputs at reset values.

Source files
------------

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between two requesters.
// Builds byte enables/lane data, flags illegal accesses, and returns extended load data one cycle later.
module dm_arbiter #(
    parameter logic [31:0] ADDR_MAX = 32'h0000_2fff,
    parameter int          LOCK_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [1:0]  m0_size,
    input  logic        m0_sext,
    input  logic        m0_lock,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [1:0]  m1_size,
    input  logic        m1_sext,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] dm_A,
    output logic        dm_MemWrite,
    output logic [31:0] dm_WD,
    output logic [3:0]  dm_BE,
    input  logic [31:0] dm_RD
);
    localparam int            CW    = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LMAX  = CW'(LOCK_MAX);

    logic [1:0]        req, lock, gnt;
    logic              own_act, gnt_vld, win;
    logic              last_q, last_d;
    logic              own_vld_q, own_vld_d, own_id_q, own_id_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              we, sext, legal;
    logic [31:0]       addr, wdata, wd, rdata_d, sh_b, sh_h;
    logic [1:0]        size;
    logic [3:0]        be;
    logic [1:0]        rvalid_q, err_q;
    logic [1:0][31:0]  rdata_q;

    assign req  = {m1_req, m0_req};
    assign lock = {m1_lock, m0_lock};

    always_comb begin
        own_act = own_vld_q && req[own_id_q] && lock[own_id_q] && (cnt_q < LMAX);
        gnt_vld = (|req) && !reset;
        if (own_act)           win = own_id_q;
        else if (req == 2'b11) win = ~last_q;
        else                   win = req[1];
        gnt = gnt_vld ? (win ? 2'b10 : 2'b01) : 2'b00;
    end

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    assign addr  = win ? m1_addr  : m0_addr;
    assign wdata = win ? m1_wdata : m0_wdata;
    assign size  = win ? m1_size  : m0_size;
    assign we    = win ? m1_we    : m0_we;
    assign sext  = win ? m1_sext  : m0_sext;

    always_comb begin
        legal = (addr <= ADDR_MAX);
        be    = 4'b0000;
        wd    = wdata;
        case (size)
            2'b00: begin
                be = 4'b0001 << addr[1:0];
                wd = {4{wdata[7:0]}};
            end
            2'b01: begin
                be = addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata[15:0]}};
                if (addr[0]) legal = 1'b0;
            end
            2'b10: begin
                be = 4'b1111;
                if (addr[1:0] != 2'b00) legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
    end

    assign dm_A        = gnt_vld ? addr : 32'h0;
    assign dm_WD       = gnt_vld ? wd : 32'h0;
    assign dm_BE       = (gnt_vld && legal) ? be : 4'b0000;
    assign dm_MemWrite = gnt_vld && legal && we;

    // Lane extraction from the word DM returns for the granted address.
    always_comb begin
        sh_b = dm_RD >> {addr[1:0], 3'b000};
        sh_h = dm_RD >> {addr[1], 4'b0000};
        case (size)
            2'b00:   rdata_d = sext ? {{24{sh_b[7]}}, sh_b[7:0]} : {24'h0, sh_b[7:0]};
            2'b01:   rdata_d = sext ? {{16{sh_h[15]}}, sh_h[15:0]} : {16'h0, sh_h[15:0]};
            default: rdata_d = dm_RD;
        endcase
    end

    // Lock window saturates at LOCK_MAX so the owner loses priority until ownership changes.
    always_comb begin
        last_d    = last_q;
        own_vld_d = 1'b0;
        own_id_d  = own_id_q;
        cnt_d     = '0;
        if (gnt_vld) begin
            last_d = win;
            if (lock[win]) begin
                own_vld_d = 1'b1;
                own_id_d  = win;
                if (own_vld_q && own_id_q == win)
                    cnt_d = (cnt_q == LMAX) ? cnt_q : cnt_q + 1'b1;
                else
                    cnt_d = CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q    <= 1'b1;
            own_vld_q <= 1'b0;
            own_id_q  <= 1'b0;
            cnt_q     <= '0;
            rvalid_q  <= 2'b00;
            err_q     <= 2'b00;
            rdata_q   <= '0;
        end else begin
            last_q    <= last_d;
            own_vld_q <= own_vld_d;
            own_id_q  <= own_id_d;
            cnt_q     <= cnt_d;
            rvalid_q  <= gnt;
            for (int i = 0; i < 2; i++) begin
                err_q[i] <= gnt[i] && !legal;
                if (gnt[i]) rdata_q[i] <= (legal && !we) ? rdata_d : 32'h0;
            end
        end
    end

    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign m0_rdata  = rdata_q[0];
    assign m1_rdata  = rdata_q[1];
endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: byte-level memory model plus rule-based arbitration model,
// expected responses queued per master and checked by an independent monitor.
module tb_dm_arbiter;
    localparam logic [31:0] ADDR_MAX = 32'h0000_2fff;
    localparam int          LOCK_MAX = 8;

    typedef struct {
        logic        req, we;
        logic [31:0] addr, wdata;
        logic [1:0]  size;
        logic        sext, lock;
    } req_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic clk = 0, reset = 1;
    logic m0_req = 0, m0_we = 0, m0_sext = 0, m0_lock = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0;
    logic [1:0]  m0_size = 0;
    logic m1_req = 0, m1_we = 0, m1_sext = 0, m1_lock = 0;
    logic [31:0] m1_addr = 0, m1_wdata = 0;
    logic [1:0]  m1_size = 0;
    logic m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] dm_A, dm_WD, dm_RD;
    logic        dm_MemWrite;
    logic [3:0]  dm_BE;

    int nchk = 0, nfail = 0;

    dm_arbiter #(.ADDR_MAX(ADDR_MAX), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_size(m0_size), .m0_sext(m0_sext), .m0_lock(m0_lock), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_size(m1_size), .m1_sext(m1_sext), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .dm_A(dm_A), .dm_MemWrite(dm_MemWrite), .dm_WD(dm_WD), .dm_BE(dm_BE), .dm_RD(dm_RD)
    );

    always #5 clk = ~clk;

    // Data memory attached to the dm_* port.
    logic [31:0] dmem [0:4095];
    initial for (int i = 0; i < 4096; i++) dmem[i] = 32'h0;
    always @(posedge clk)
        if (dm_MemWrite)
            for (int i = 0; i < 4; i++)
                if (dm_BE[i]) dmem[dm_A[13:2]][8*i +: 8] <= dm_WD[8*i +: 8];
    assign dm_RD = dmem[dm_A[13:2]];

    // Reference state
    logic [7:0] mm [int];
    rsp_t q0[$], q1[$];
    int last = 1, own = -1, run = 0;

    function automatic logic [7:0] rb(input logic [31:0] a);
        return mm.exists(int'(a)) ? mm[int'(a)] : 8'h00;
    endfunction

    task automatic check(input string n, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", n, act, exp, $time);
        end
    endtask

    task automatic chk_rsp(input int m, input logic v, input logic [31:0] d, input logic er);
        rsp_t e;
        int   sz;
        sz = (m == 0) ? q0.size() : q1.size();
        if (v) begin
            if (sz == 0) begin
                nchk++; nfail++;
                $display("FAIL rsp%0d unexpected rvalid actual=1 expected=0 t=%0t", m, $time);
            end else begin
                e = (m == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("rsp%0d", m), {95'h0, er, d}, {95'h0, e.err, e.rdata});
            end
        end else if (sz != 0) begin
            e = (m == 0) ? q0.pop_front() : q1.pop_front();
            nchk++; nfail++;
            $display("FAIL rsp%0d missing rvalid actual=0 expected=1 t=%0t", m, $time);
        end
    endtask

    initial forever begin
        @(posedge clk); #1;
        chk_rsp(0, m0_rvalid, m0_rdata, m0_err);
        chk_rsp(1, m1_rvalid, m1_rdata, m1_err);
    end

    task automatic step(input req_t a, input req_t b, input logic rst);
        req_t r[2];
        int w, nb, off;
        logic lg;
        logic [3:0] be;
        logic [31:0] wd, v;
        rsp_t e;
        r[0] = a; r[1] = b;
        @(negedge clk);
        reset = rst;
        m0_req = a.req; m0_we = a.we; m0_addr = a.addr; m0_wdata = a.wdata;
        m0_size = a.size; m0_sext = a.sext; m0_lock = a.lock;
        m1_req = b.req; m1_we = b.we; m1_addr = b.addr; m1_wdata = b.wdata;
        m1_size = b.size; m1_sext = b.sext; m1_lock = b.lock;
        #1;
        w = -1;
        if (!rst) begin
            if (own >= 0 && r[own].req && r[own].lock && run < LOCK_MAX) w = own;
            else if (a.req && b.req) w = (last == 0) ? 1 : 0;
            else if (a.req) w = 0;
            else if (b.req) w = 1;
        end
        check("gnt", {126'h0, m1_gnt, m0_gnt}, (w < 0) ? 128'd0 : (w == 0) ? 128'd1 : 128'd2);
        if (w < 0) begin
            check("idle", {59'h0, dm_A, dm_WD, dm_BE, dm_MemWrite}, 128'h0);
            if (rst) begin last = 1; own = -1; run = 0; end
            else begin own = -1; run = 0; end
        end else begin
            off = int'(r[w].addr[1:0]);
            nb  = 1 << r[w].size;
            lg  = !(r[w].size == 2'b11 || (r[w].size == 2'b01 && r[w].addr[0]) ||
                    (r[w].size == 2'b10 && off != 0) || r[w].addr > ADDR_MAX);
            for (int i = 0; i < 4; i++) be[i] = lg && (i >= off) && (i < off + nb);
            case (r[w].size)
                2'b00:   wd = {4{r[w].wdata[7:0]}};
                2'b01:   wd = {2{r[w].wdata[15:0]}};
                default: wd = r[w].wdata;
            endcase
            check("dm_A", {96'h0, dm_A}, {96'h0, r[w].addr});
            check("dm_we_be", {123'h0, dm_MemWrite, dm_BE}, {123'h0, lg && r[w].we, be});
            if (lg && r[w].we) check("dm_WD", {96'h0, dm_WD}, {96'h0, wd});
            e.err = !lg;
            e.rdata = 32'h0;
            if (lg && !r[w].we) begin
                v = {rb(r[w].addr + 3), rb(r[w].addr + 2), rb(r[w].addr + 1), rb(r[w].addr)};
                case (r[w].size)
                    2'b00:   e.rdata = r[w].sext ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
                    2'b01:   e.rdata = r[w].sext ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
                    default: e.rdata = v;
                endcase
            end
            if (lg && r[w].we)
                for (int i = 0; i < nb; i++) mm[int'(r[w].addr) + i] = r[w].wdata[8*i +: 8];
            if (w == 0) q0.push_back(e); else q1.push_back(e);
            last = w;
            if (r[w].lock) begin
                if (own == w) run = (run < LOCK_MAX) ? run + 1 : run;
                else begin own = w; run = 1; end
            end else begin
                own = -1; run = 0;
            end
        end
    endtask

    function automatic req_t mk(input logic rq, input logic we, input logic [31:0] ad,
                                input logic [31:0] wd, input logic [1:0] sz, input logic sx,
                                input logic lk);
        req_t r;
        r.req = rq; r.we = we; r.addr = ad; r.wdata = wd; r.size = sz; r.sext = sx; r.lock = lk;
        return r;
    endfunction

    function automatic req_t rnd(input logic lk_bias);
        req_t r;
        r.req   = ($urandom_range(0, 3) != 0);
        r.we    = $urandom_range(0, 1);
        r.addr  = ($urandom_range(0, 3) == 3) ? 32'h2ff8 + $urandom_range(0, 15)
                                              : 32'($urandom_range(0, 47));
        r.wdata = $urandom;
        r.size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        r.sext  = $urandom_range(0, 1);
        r.lock  = lk_bias ? 1'b1 : ($urandom_range(0, 3) == 0);
        return r;
    endfunction

    initial begin
        req_t idle, a, b;
        logic b0, b1;
        idle = mk(0, 0, 0, 0, 0, 0, 0);
        step(idle, idle, 1);
        step(idle, idle, 1);
        @(posedge clk); #2;
        check("reset_out", {58'h0, m0_rvalid, m0_err, m0_rdata, m1_rvalid, m1_err, m1_rdata}, 128'h0);
        // store then byte load with sign extension
        step(mk(1, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 0), idle, 0);
        step(mk(1, 0, 32'h11, 0, 2'b00, 1, 0), idle, 0);
        // half store/load on upper lanes
        step(idle, mk(1, 1, 32'h22, 32'h1234, 2'b01, 0, 0), 0);
        step(idle, mk(1, 0, 32'h22, 0, 2'b01, 0, 0), 0);
        // both request continuously: alternation
        for (int i = 0; i < 6; i++)
            step(mk(1, 0, 32'h10, 0, 2'b10, 0, 0), mk(1, 0, 32'h20, 0, 2'b10, 0, 0), 0);
        // m1 gets the lock first, then m0 contends
        step(idle, mk(1, 0, 32'h20, 0, 2'b10, 0, 1), 0);
        for (int i = 0; i < 12; i++)
            step(mk(1, 0, 32'h10, 0, 2'b10, 0, 0), mk(1, 0, 32'h20, 0, 2'b10, 0, 1), 0);
        step(idle, idle, 0);
        // illegal accesses, then readback of the untouched word
        step(mk(1, 1, 32'h2, 32'hAAAAAAAA, 2'b10, 0, 0), idle, 0);
        step(mk(1, 1, 32'h3000, 32'h55555555, 2'b10, 0, 0), idle, 0);
        step(mk(1, 0, 32'h0, 0, 2'b10, 0, 0), idle, 0);
        step(mk(1, 0, 32'h2ffc, 0, 2'b10, 0, 0), idle, 0);
        // reset while a load is presented
        step(mk(1, 0, 32'h10, 0, 2'b10, 0, 0), idle, 1);
        step(idle, idle, 0);
        // randomized traffic
        b0 = 0; b1 = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0) begin
                b0 = ($urandom_range(0, 3) == 0);
                b1 = ($urandom_range(0, 3) == 0);
            end
            a = rnd(b0);
            b = rnd(b1);
            step(a, b, $urandom_range(0, 99) == 0);
        end
        step(idle, idle, 0);
        step(idle, idle, 0);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
